// File: rtl/ad9511_spi_responder_if.sv
// rtl/ad9511_spi_responder_if.sv - 3-wire SPI pin bundle between configuration initiator and AD9511 responder
interface ad9511_spi_responder_if;
   logic spi_sclk;
   logic spi_csb;
   logic spi_sdi;
   logic spi_sdo;
   logic spi_sdo_oe;

   modport master (output spi_sclk, output spi_csb, output spi_sdi,
                   input spi_sdo, input spi_sdo_oe);
   modport slave  (input spi_sclk, input spi_csb, input spi_sdi,
                   output spi_sdo, output spi_sdo_oe);
endinterface

// File: rtl/ad9511_spi_responder.sv
// rtl/ad9511_spi_responder.sv - AD9511-style SPI register responder, oversampled; readback via AD9511_RSP_READBACK_EN
module ad9511_spi_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 7
) (
   input  logic                  clk,
   input  logic                  reset_n,
   ad9511_spi_responder_if.slave spi,
   input  logic [ADDR_W-1:0]     reg_rd_addr,
   output logic [7:0]            reg_rd_data,
   output logic                  update_pulse,
   output logic                  frame_done,
   output logic                  frame_error,
   output logic [15:0]           write_count
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] XFER_ADDR = ADDR_W'(7'h5A);

   typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, DONE} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync, csb_sync, sdi_sync;
   logic                   sclk_q, csb_q;
   logic                   sclk_s, csb_s, sdi_s;
   logic                   sclk_rise, sclk_fall, csb_rise, csb_fall;

   state_t                 state;
   logic [4:0]             bit_cnt;
   logic [1:0]             byte_cnt;
   logic                   stream;
   logic [14:0]            shift;
   logic [ADDR_W-1:0]      addr;
   logic [ADDR_W-1:0]      addr_dec;
   logic [7:0]             shadow [DEPTH];
   logic [7:0]             active [DEPTH];

   // Synchronize the pins; csb chain resets low so a frame already in progress at
   // reset release is not mistaken for a new one until csb has been seen high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= '0;
         csb_sync  <= '0;
         sdi_sync  <= '0;
         sclk_q    <= 1'b0;
         csb_q     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
         csb_sync  <= {csb_sync[SYNC_STAGES-2:0], spi.spi_csb};
         sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi.spi_sdi};
         sclk_q    <= sclk_sync[SYNC_STAGES-1];
         csb_q     <= csb_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign csb_s     = csb_sync[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s & sclk_q;
   assign csb_rise  = csb_s & ~csb_q;
   assign csb_fall  = ~csb_s & csb_q;
   assign addr_dec  = addr - ADDR_W'(1);

   assign reg_rd_data = active[reg_rd_addr];

`ifdef AD9511_RSP_READBACK_EN
   logic       sdo_q, sdo_oe_q;
   logic [6:0] rd_shift;
   assign spi.spi_sdo    = sdo_q;
   assign spi.spi_sdo_oe = sdo_oe_q;
`else
   assign spi.spi_sdo    = 1'b0;
   assign spi.spi_sdo_oe = 1'b0;
`endif

   // Frame FSM: instruction decode, shadow writes, 0x5A transfer and readback shifting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         byte_cnt     <= '0;
         stream       <= 1'b0;
         shift        <= '0;
         addr         <= '0;
         shadow       <= '{default: 8'h00};
         active       <= '{default: 8'h00};
         update_pulse <= 1'b0;
         frame_done   <= 1'b0;
         frame_error  <= 1'b0;
         write_count  <= '0;
`ifdef AD9511_RSP_READBACK_EN
         sdo_q        <= 1'b0;
         sdo_oe_q     <= 1'b0;
         rd_shift     <= '0;
`endif
      end else begin
         update_pulse <= 1'b0;
         frame_done   <= 1'b0;
         frame_error  <= 1'b0;
         if (state == IDLE) begin
            if (csb_fall) begin
               state   <= INSTR;
               bit_cnt <= '0;
            end
         end else if (csb_rise) begin
            // csb wins over a coincident SCLK edge; a mid-byte end discards the partial byte
            if (state == DONE ||
                (stream && bit_cnt == 5'd0 && (state == WDATA || state == RDATA)))
               frame_done <= 1'b1;
            else
               frame_error <= 1'b1;
            state <= IDLE;
`ifdef AD9511_RSP_READBACK_EN
            sdo_q    <= 1'b0;
            sdo_oe_q <= 1'b0;
`endif
         end else begin
            case (state)
               INSTR: begin
                  if (sclk_rise) begin
                     shift <= {shift[13:0], sdi_s};
                     if (bit_cnt == 5'd15) begin
                        addr     <= {shift[ADDR_W-2:0], sdi_s};
                        byte_cnt <= shift[13:12];
                        stream   <= &shift[13:12];
                        bit_cnt  <= '0;
                        state    <= shift[14] ? RDATA : WDATA;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               WDATA: begin
                  if (sclk_rise) begin
                     shift <= {shift[13:0], sdi_s};
                     if (bit_cnt == 5'd7) begin
                        bit_cnt     <= '0;
                        addr        <= addr_dec;
                        write_count <= write_count + 16'd1;
                        if (addr == XFER_ADDR) begin
                           if (sdi_s) begin
                              update_pulse <= 1'b1;
                              active       <= shadow;
                           end
                        end else begin
                           shadow[addr] <= {shift[6:0], sdi_s};
                        end
                        if (!stream) begin
                           if (byte_cnt == 2'd0)
                              state <= DONE;
                           else
                              byte_cnt <= byte_cnt - 2'd1;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               RDATA: begin
                  // Rises count bits sampled by the initiator; falls move data so the
                  // last bit stays driven for its full period.
                  if (sclk_rise) begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end else if (sclk_fall) begin
                     if (bit_cnt == 5'd8) begin
                        addr    <= addr_dec;
                        bit_cnt <= '0;
                        if (!stream && byte_cnt == 2'd0) begin
                           state <= DONE;
`ifdef AD9511_RSP_READBACK_EN
                           sdo_q    <= 1'b0;
                           sdo_oe_q <= 1'b0;
`endif
                        end else begin
                           if (!stream)
                              byte_cnt <= byte_cnt - 2'd1;
`ifdef AD9511_RSP_READBACK_EN
                           {sdo_q, rd_shift} <= active[addr_dec];
                           sdo_oe_q          <= 1'b1;
`endif
                        end
                     end
`ifdef AD9511_RSP_READBACK_EN
                     else if (bit_cnt == 5'd0) begin
                        {sdo_q, rd_shift} <= active[addr];
                        sdo_oe_q          <= 1'b1;
                     end else begin
                        sdo_q    <= rd_shift[6];
                        rd_shift <= {rd_shift[5:0], 1'b0};
                     end
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ad9511_spi_responder.sv
// tb/tb_ad9511_spi_responder.sv - directed table-driven bench for ad9511_spi_responder
module tb_ad9511_spi_responder;
   localparam int HALF = 80;

   typedef struct {
      logic [15:0] instr;
      logic [31:0] data;
      int          nbits;
      int          exp_done;
      int          exp_err;
      int          exp_upd;
      logic [15:0] exp_wc;
      logic [6:0]  chk_addr;
      logic [7:0]  chk_val;
   } vec_t;

   logic        clk;
   logic        reset_n;
   logic [6:0]  reg_rd_addr;
   logic [7:0]  reg_rd_data;
   logic        update_pulse;
   logic        frame_done;
   logic        frame_error;
   logic [15:0] write_count;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int upd_cnt = 0;
   int oe_cnt = 0;

   vec_t vecs [19];

   ad9511_spi_responder_if spi_if ();

   ad9511_spi_responder #(.SYNC_STAGES(2), .ADDR_W(7)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .spi          (spi_if),
      .reg_rd_addr  (reg_rd_addr),
      .reg_rd_data  (reg_rd_data),
      .update_pulse (update_pulse),
      .frame_done   (frame_done),
      .frame_error  (frame_error),
      .write_count  (write_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count pulses and drive-enable cycles away from the active edge.
   always @(negedge clk) begin
      if (frame_done)        done_cnt = done_cnt + 1;
      if (frame_error)       err_cnt  = err_cnt + 1;
      if (update_pulse)      upd_cnt  = upd_cnt + 1;
      if (spi_if.spi_sdo_oe) oe_cnt   = oe_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic spi_bit(input logic b);
      spi_if.spi_sdi = b;
      #HALF;
      spi_if.spi_sclk = 1'b1;
      #HALF;
      spi_if.spi_sclk = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int d0, e0, u0;
      logic [47:0] bits;
      d0 = done_cnt;
      e0 = err_cnt;
      u0 = upd_cnt;
      bits = {v.instr, v.data};
      spi_if.spi_csb = 1'b0;
      #HALF;
      for (int i = 0; i < v.nbits; i++) spi_bit(bits[47-i]);
      spi_if.spi_sdi = 1'b0;
      #HALF;
      spi_if.spi_csb = 1'b1;
      #(2*HALF);
      check({tag, "_done"}, done_cnt - d0, v.exp_done);
      check({tag, "_err"}, err_cnt - e0, v.exp_err);
      check({tag, "_upd"}, upd_cnt - u0, v.exp_upd);
      check({tag, "_wcount"}, write_count, v.exp_wc);
      reg_rd_addr = v.chk_addr;
      #2;
      check({tag, "_rd"}, reg_rd_data, v.chk_val);
      #8;
   endtask

   task automatic read_frame(input logic [15:0] instr, input logic [7:0] exp, input logic [15:0] exp_wc);
      int d0, e0, o0;
      logic [7:0] rb;
      d0 = done_cnt;
      e0 = err_cnt;
      o0 = oe_cnt;
      rb = exp;
      spi_if.spi_csb = 1'b0;
      #HALF;
      for (int i = 0; i < 16; i++) spi_bit(instr[15-i]);
      spi_if.spi_sdi = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #HALF;
`ifdef AD9511_RSP_READBACK_EN
         check($sformatf("rd_sdo_bit%0d", i), spi_if.spi_sdo, rb[7-i]);
         check($sformatf("rd_oe_bit%0d", i), spi_if.spi_sdo_oe, 1'b1);
`else
         check($sformatf("rd_sdo_bit%0d", i), spi_if.spi_sdo, 1'b0);
         check($sformatf("rd_oe_bit%0d", i), spi_if.spi_sdo_oe, 1'b0);
`endif
         spi_if.spi_sclk = 1'b1;
         #HALF;
         spi_if.spi_sclk = 1'b0;
      end
      #HALF;
      spi_if.spi_csb = 1'b1;
      #(2*HALF);
      check("rd_done", done_cnt - d0, 1);
      check("rd_err", err_cnt - e0, 0);
      check("rd_wcount", write_count, exp_wc);
`ifdef AD9511_RSP_READBACK_EN
      check("rd_oe_cycles", oe_cnt - o0, 8 * 2 * HALF / 10);
`else
      check("rd_oe_cycles", oe_cnt - o0, 0);
`endif
   endtask

   initial begin
      int d0, e0;
      vec_t v;

      vecs[0]  = '{16'h0004, 32'hA500_0000, 24, 1, 0, 0, 16'd1,  7'h04, 8'h00};
      vecs[1]  = '{16'h005A, 32'h0100_0000, 24, 1, 0, 1, 16'd2,  7'h04, 8'hA5};
      vecs[2]  = '{16'h2005, 32'h1122_0000, 32, 1, 0, 0, 16'd4,  7'h05, 8'h00};
      vecs[3]  = '{16'h005A, 32'h0000_0000, 24, 1, 0, 0, 16'd5,  7'h05, 8'h00};
      vecs[4]  = '{16'h005A, 32'h0100_0000, 24, 1, 0, 1, 16'd6,  7'h05, 8'h11};
      vecs[5]  = '{16'h005A, 32'h0100_0000, 24, 1, 0, 1, 16'd7,  7'h04, 8'h22};
      vecs[6]  = '{16'h005A, 32'h0100_0000, 24, 1, 0, 1, 16'd8,  7'h5A, 8'h00};
      vecs[7]  = '{16'h2000, 32'h3344_0000, 32, 1, 0, 0, 16'd10, 7'h00, 8'h00};
      vecs[8]  = '{16'h005A, 32'hFF00_0000, 24, 1, 0, 1, 16'd11, 7'h00, 8'h33};
      vecs[9]  = '{16'h005A, 32'h0100_0000, 24, 1, 0, 1, 16'd12, 7'h7F, 8'h44};
      vecs[10] = '{16'h0010, 32'hFF00_0000, 20, 0, 1, 0, 16'd12, 7'h10, 8'h00};
      vecs[11] = '{16'h005A, 32'h0100_0000, 24, 1, 0, 1, 16'd13, 7'h10, 8'h00};
      vecs[12] = '{16'h6003, 32'h7766_0000, 32, 1, 0, 0, 16'd15, 7'h03, 8'h00};
      vecs[13] = '{16'h005A, 32'h0100_0000, 24, 1, 0, 1, 16'd16, 7'h03, 8'h77};
      vecs[14] = '{16'h005A, 32'h0100_0000, 24, 1, 0, 1, 16'd17, 7'h02, 8'h66};
      vecs[15] = '{16'h1F84, 32'hBB00_0000, 24, 1, 0, 0, 16'd18, 7'h04, 8'h22};
      vecs[16] = '{16'h005A, 32'h0100_0000, 24, 1, 0, 1, 16'd19, 7'h04, 8'hBB};
      vecs[17] = '{16'h6003, 32'h55F0_0000, 28, 0, 1, 0, 16'd20, 7'h03, 8'h77};
      vecs[18] = '{16'h005A, 32'h0100_0000, 24, 1, 0, 1, 16'd21, 7'h03, 8'h55};

      reset_n = 1'b0;
      spi_if.spi_sclk = 1'b0;
      spi_if.spi_csb = 1'b1;
      spi_if.spi_sdi = 1'b0;
      reg_rd_addr = 7'h00;
      #40;
      check("rst_wcount", write_count, 16'd0);
      check("rst_pulses", {update_pulse, frame_done, frame_error}, 3'b000);
      check("rst_sdo", {spi_if.spi_sdo, spi_if.spi_sdo_oe}, 2'b00);
      check("rst_rd_data", reg_rd_data, 8'h00);
      reset_n = 1'b1;
      #40;

      for (int k = 0; k < 19; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

      v = '{16'h0004, 32'hA500_0000, 24, 1, 0, 0, 16'd22, 7'h04, 8'hBB};
      run_vec(v, "rdprep_wr");
      v = '{16'h005A, 32'h0100_0000, 24, 1, 0, 1, 16'd23, 7'h04, 8'hA5};
      run_vec(v, "rdprep_upd");
      read_frame(16'h8004, 8'hA5, 16'd23);

      // Reset in the middle of an instruction, then finish that frame with csb still low.
      spi_if.spi_csb = 1'b0;
      #HALF;
      for (int i = 0; i < 8; i++) spi_bit(1'b0);
      reset_n = 1'b0;
      reg_rd_addr = 7'h04;
      #20;
      check("midrst_wcount", write_count, 16'd0);
      check("midrst_rd_data", reg_rd_data, 8'h00);
      check("midrst_pulses", {update_pulse, frame_done, frame_error}, 3'b000);
      check("midrst_sdo", {spi_if.spi_sdo, spi_if.spi_sdo_oe}, 2'b00);
      reset_n = 1'b1;
      #20;
      d0 = done_cnt;
      e0 = err_cnt;
      for (int i = 0; i < 16; i++) spi_bit((i == 5) || (i >= 8));
      #HALF;
      spi_if.spi_csb = 1'b1;
      #(2*HALF);
      check("midrst_tail_done", done_cnt - d0, 0);
      check("midrst_tail_err", err_cnt - e0, 0);
      check("midrst_tail_wcount", write_count, 16'd0);

      v = '{16'h0004, 32'h5C00_0000, 24, 1, 0, 0, 16'd1, 7'h04, 8'h00};
      run_vec(v, "postrst_wr");
      v = '{16'h005A, 32'h0100_0000, 24, 1, 0, 1, 16'd2, 7'h04, 8'h5C};
      run_vec(v, "postrst_upd");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
